div_clk_ctrl: RTL

Programmable, run-time reconfigurable clock-divider controller for the divider family in this design. It generates a divided clock (`clk_out`) and a one-cycle period-start strobe (`tick`) from `clk`. A valid/ready configuration port loads new divide ratios, and every ratio change, start and stop happens only on a period boundary, so `clk_out` never produces a runt pulse. Downstream blocks use `clk_out` as a slow clock or `tick` as a clock enable.

---
 rtl/div_clk_ctrl.sv | 73 +++++++
 1 files changed

// File: rtl/div_clk_ctrl.sv
// div_clk_ctrl: run-time reconfigurable clock divider; ratio changes, starts and stops land only on period boundaries.
module div_clk_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] PEND = 2'd2;

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, pend_div, pend_nx, div_nx, h;
    logic             hs, ok, acc, wrap;

    assign cfg_ready = state != PEND;
    assign busy      = state != IDLE;
    assign hs        = cfg_valid & cfg_ready;
    assign ok        = cfg_div >= CNT_W'(2);
    assign acc       = hs & ok;
    assign wrap      = busy & (cnt == cur_div - CNT_W'(1));
    // high time uses the ratio of the period being counted
    assign h         = cur_div - (cur_div >> 1);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        pend_nx  = acc ? cfg_div : pend_div;
        div_nx   = cur_div;
        if (state == IDLE) begin
            cnt_nx   = '0;
            div_nx   = acc ? cfg_div : cur_div;
            state_nx = en ? RUN : IDLE;
        end else if (wrap) begin
            cnt_nx   = '0;
            // a ratio accepted on a stopping wrap has no later boundary, so it loads directly
            div_nx   = (acc & ~en) ? cfg_div : (state == PEND) ? pend_div : cur_div;
            state_nx = !en ? IDLE : acc ? PEND : RUN;
        end else begin
            state_nx = acc ? PEND : state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_div  <= CNT_W'(DIV_DEFAULT);
            pend_div <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            cur_div  <= div_nx;
            pend_div <= pend_nx;
            clk_out  <= (state_nx != IDLE) && (cnt_nx < h);
            tick     <= (state_nx != IDLE) && (cnt_nx == '0);
            cfg_err  <= hs & ~ok;
        end
    end
endmodule
